// File: rtl/clk_gen_pkg.sv
// Shared types and default constants for the multi-channel clock divider.
package clk_gen_pkg;

    typedef enum logic {
        WAIT_LOCK,
        READY
    } lock_st_t;

    typedef enum logic {
        OFF,
        RUN
    } chan_st_t;

    localparam int NCH_DEF       = 3;
    localparam int DIV_W_DEF     = 8;
    localparam int LOCK_WAIT_DEF = 16;
    localparam int DEF_DIV_DEF   = 1;

endpackage

// File: rtl/clk_gen_chan.sv
// One divided-clock channel: pending/active ratio, half-period counter,
// 0/180 phase outputs and a rising-edge strobe.
module clk_gen_chan
    import clk_gen_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk_c_0,
    input  logic             pll_lock,
    input  logic             i_ready,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_ratio,
    output logic             o_clk0,
    output logic             o_clk180,
    output logic             o_stb
);

    chan_st_t         r_state;
    logic [DIV_W-1:0] r_pend;
    logic [DIV_W-1:0] r_act;
    logic [DIV_W-1:0] r_cnt;
    logic             r_ph;
    logic             r_ph_n;
    logic             r_stb;

    logic [DIV_W-1:0] w_pend_nxt;
    logic             w_go;
    logic             w_nz;
    logic             w_wrap;

    // A load on the boundary cycle is seen by the boundary itself
    assign w_pend_nxt = i_load ? i_ratio : r_pend;
    assign w_go       = i_ready & i_en;
    assign w_nz       = (r_act != '0);
    assign w_wrap     = (r_cnt == r_act - DIV_W'(1));

    always_ff @(posedge clk_c_0 or negedge pll_lock) begin
        if (!pll_lock) begin
            r_state <= OFF;
            r_pend  <= DIV_W'(DEF_DIV);
            r_act   <= DIV_W'(DEF_DIV);
            r_cnt   <= '0;
            r_ph    <= 1'b0;
            r_ph_n  <= 1'b1;
            r_stb   <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            unique case (r_state)
                OFF: begin
                    r_cnt  <= '0;
                    r_ph   <= 1'b0;
                    r_ph_n <= 1'b1;
                    r_stb  <= 1'b0;
                    r_act  <= w_pend_nxt;
                    if (w_go && w_nz) r_state <= RUN;
                end
                RUN: begin
                    if (!w_go || !w_nz) begin
                        r_state <= OFF;
                        r_cnt   <= '0;
                        r_ph    <= 1'b0;
                        r_ph_n  <= 1'b1;
                        r_stb   <= 1'b0;
                        r_act   <= w_pend_nxt;
                    end else if (w_wrap) begin
                        r_cnt  <= '0;
                        r_ph   <= ~r_ph;
                        r_ph_n <= r_ph;
                        r_stb  <= ~r_ph;
                        // Ratio changes only between whole periods
                        if (r_ph) r_act <= w_pend_nxt;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                        r_stb <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_clk0   = r_ph;
    assign o_clk180 = r_ph_n;
    assign o_stb    = r_stb;

endmodule

// File: rtl/clk_gen_multi.sv
// Lock-wait FSM plus NCH independent divided-clock channels.
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int DIV_W     = DIV_W_DEF,
    parameter int LOCK_WAIT = LOCK_WAIT_DEF,
    parameter int DEF_DIV   = DEF_DIV_DEF
) (
    input  logic                 clk_c_0,
    input  logic                 pll_lock,
    input  logic [NCH*DIV_W-1:0] div_ratio,
    input  logic [NCH-1:0]       div_load,
    input  logic [NCH-1:0]       ch_en,
    output logic [NCH-1:0]       clk_o_0,
    output logic [NCH-1:0]       clk_o_180,
    output logic [NCH-1:0]       stb_rise,
    output logic                 ready
);

    localparam int CW = $clog2(LOCK_WAIT + 1);

    lock_st_t      r_state;
    logic [CW-1:0] r_lock_cnt;
    logic          r_ready;

    always_ff @(posedge clk_c_0 or negedge pll_lock) begin
        if (!pll_lock) begin
            r_state    <= WAIT_LOCK;
            r_lock_cnt <= '0;
            r_ready    <= 1'b0;
        end else begin
            unique case (r_state)
                WAIT_LOCK: begin
                    if (r_lock_cnt == CW'(LOCK_WAIT - 1)) begin
                        r_state <= READY;
                        r_ready <= 1'b1;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + CW'(1);
                    end
                end
                READY: r_ready <= 1'b1;
            endcase
        end
    end

    assign ready = r_ready;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_gen_chan #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_c_0  (clk_c_0),
            .pll_lock (pll_lock),
            .i_ready  (r_ready),
            .i_en     (ch_en[g]),
            .i_load   (div_load[g]),
            .i_ratio  (div_ratio[g*DIV_W +: DIV_W]),
            .o_clk0   (clk_o_0[g]),
            .o_clk180 (clk_o_180[g]),
            .o_stb    (stb_rise[g])
        );
    end

endmodule
